// File: rtl/wolverine_dispatch_responder.sv
// Purpose : AE-side responder for the Wolverine host dispatch interface. It holds the
//           AEG register file, answers host register reads and writes, and launches
//           dispatched instructions to the accelerator core.
// Latency : host AEG read returns 1 cycle after the request. AEG writes land on the
//           request edge. An accepted instruction is offered on start_valid the next cycle.
// Backpr. : start_valid/start_inst hold steady until start_ready. disp_stall is high
//           from the cycle after acceptance until acc_done.
//
// Ports
//   clock, reset              single clock; synchronous active-low reset
//   disp_inst_valid/_data     host instruction dispatch (5-bit opcode)
//   disp_reg_id/read/write    host AEG access; write data on disp_reg_wr_data
//   disp_aeg_cnt              constant AEG_CNT
//   disp_exception            sticky exception bits
//   disp_idle / disp_stall    dispatch status from the registered FSM state
//   disp_rtn_valid/_data      host AEG read return
//   start_valid/ready/inst    launch handshake to the accelerator
//   acc_done                  accelerator finished the current instruction
//   acc_exc_valid/_code       accelerator exception report, merged into bits [15:4]
//   acc_wr_valid/id/data      accelerator AEG write (result return)
//   acc_rd_id / acc_rd_data   combinational accelerator AEG read
module wolverine_dispatch_responder #(
  parameter int AEG_CNT  = 16,
  parameter int NUM_INST = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        disp_inst_valid,
  input  logic [4:0]  disp_inst_data,
  input  logic [17:0] disp_reg_id,
  input  logic        disp_reg_read,
  input  logic        disp_reg_write,
  input  logic [63:0] disp_reg_wr_data,
  output logic [17:0] disp_aeg_cnt,
  output logic [15:0] disp_exception,
  output logic        disp_idle,
  output logic        disp_stall,
  output logic        disp_rtn_valid,
  output logic [63:0] disp_rtn_data,
  output logic        start_valid,
  input  logic        start_ready,
  output logic [4:0]  start_inst,
  input  logic        acc_done,
  input  logic        acc_exc_valid,
  input  logic [11:0] acc_exc_code,
  input  logic        acc_wr_valid,
  input  logic [17:0] acc_wr_id,
  input  logic [63:0] acc_wr_data,
  input  logic [17:0] acc_rd_id,
  output logic [63:0] acc_rd_data
);

  // Index width used to address the register array. The range checks below keep
  // ids at or above AEG_CNT from ever being used as an array index.
  localparam int          IDX_W      = (AEG_CNT > 1) ? $clog2(AEG_CNT) : 1;
  localparam logic [17:0] AEG_LIMIT  = 18'(AEG_CNT);
  localparam logic [5:0]  INST_LIMIT = 6'(NUM_INST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [63:0] aeg [AEG_CNT];

  logic        host_in_range;
  logic        acc_wr_in_range;
  logic        acc_rd_in_range;
  logic        host_we;
  logic        acc_we;
  logic        host_oob;
  logic        inst_legal;
  logic        launch;
  logic        inst_bad;
  logic        overrun;
  logic [15:0] exc_set;
  logic [15:0] exc_nxt;

  assign host_in_range   = (disp_reg_id < AEG_LIMIT);
  assign acc_wr_in_range = (acc_wr_id < AEG_LIMIT);
  assign acc_rd_in_range = (acc_rd_id < AEG_LIMIT);
  assign host_we         = disp_reg_write && host_in_range;
  assign acc_we          = acc_wr_valid && acc_wr_in_range;
  assign host_oob        = (disp_reg_write || disp_reg_read) && !host_in_range;
  assign inst_legal      = ({1'b0, disp_inst_data} < INST_LIMIT);

  assign disp_aeg_cnt = AEG_LIMIT;
  assign disp_idle    = (state == ST_IDLE);
  assign disp_stall   = (state != ST_IDLE);

  // AEG register file. When host and accelerator target the same register in one
  // cycle the host write takes it. Out-of-range accelerator writes are dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < AEG_CNT; i++) begin
        aeg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < AEG_CNT; i++) begin
        if (host_we && (disp_reg_id[IDX_W-1:0] == IDX_W'(i))) begin
          aeg[i] <= disp_reg_wr_data;
        end else if (acc_we && (acc_wr_id[IDX_W-1:0] == IDX_W'(i))) begin
          aeg[i] <= acc_wr_data;
        end
      end
    end
  end

  assign acc_rd_data = acc_rd_in_range ? aeg[acc_rd_id[IDX_W-1:0]] : '0;

  // Host read return. The array is sampled before this edge's writes, so a
  // read and a write to the same id in one cycle return the old value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      disp_rtn_valid <= 1'b0;
      disp_rtn_data  <= '0;
    end else begin
      disp_rtn_valid <= disp_reg_read;
      if (disp_reg_read) begin
        disp_rtn_data <= host_in_range ? aeg[disp_reg_id[IDX_W-1:0]] : '0;
      end
    end
  end

  // Dispatch FSM: state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dispatch FSM: next state, launch strobe and exception events.
  always_comb begin
    state_nxt   = state;
    launch      = 1'b0;
    inst_bad    = 1'b0;
    overrun     = 1'b0;
    start_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (disp_inst_valid) begin
          if (inst_legal) begin
            launch    = 1'b1;
            state_nxt = ST_LAUNCH;
          end else begin
            inst_bad = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        start_valid = 1'b1;
        if (start_ready) begin
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (acc_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // The host should poll disp_stall; a dispatch while not idle is dropped and flagged.
    if (disp_inst_valid && (state != ST_IDLE)) begin
      overrun = 1'b1;
    end
  end

  // Sticky exceptions. A legal launch clears the old bits, but anything raised
  // in that same cycle still survives because the set is ORed in afterwards.
  always_comb begin
    exc_set = {(acc_exc_valid ? acc_exc_code : 12'h000), overrun, inst_bad, 1'b0, host_oob};
    exc_nxt = (launch ? 16'h0000 : disp_exception) | exc_set;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      disp_exception <= '0;
      start_inst     <= '0;
    end else begin
      disp_exception <= exc_nxt;
      if (launch) begin
        start_inst <= disp_inst_data;
      end
    end
  end

endmodule
